// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family: operation encoding used by
// the universal shift register and its future PISO/deserialiser siblings.
package shift_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHL  = 2'b01,
      MODE_SHR  = 2'b10,
      MODE_LOAD = 2'b11
   } shift_mode_t;

endpackage

// File: rtl/frame_counter.sv
// Modulo-MOD frame counter: counts inc pulses and emits a registered one-cycle
// wrap pulse on the same edge that the count returns to zero.
module frame_counter #(
   parameter  int MOD = 8,
   localparam int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(MOD - 1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (clr) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (inc) begin
         if (count == LAST) begin
            count <= '0;
            wrap  <= 1'b1;
         end else begin
            count <= count + 1'b1;
            wrap  <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_reg_universal.sv
// Parametrised universal shift register (hold / shift left / shift right / load)
// with serial taps at both ends and a frame counter flagging complete words.
module shift_reg_universal
   import shift_pkg::*;
#(
   parameter  int               WIDTH     = 8,
   parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   localparam int               CW        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [1:0]       mode,
   input  logic             sin_lsb,
   input  logic             sin_msb,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] q,
   output logic             sout_msb,
   output logic             sout_lsb,
   output logic [CW-1:0]    count,
   output logic             word_valid
);

   shift_mode_t op;
   logic        shift_inc;
   logic        cnt_clr;

   assign op = shift_mode_t'(mode);

   // NOTE: every always_comb output gets a default first, so no path through
   // the case leaves a signal unassigned and infers a latch.
   always_comb begin
      shift_inc = 1'b0;
      cnt_clr   = clr;
      case (op)
         MODE_SHL,
         MODE_SHR:  shift_inc = 1'b1;
         MODE_LOAD: cnt_clr   = 1'b1;
         default:   shift_inc = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VAL;
      end else if (clr) begin
         q <= RESET_VAL;
      end else begin
         case (op)
            MODE_SHL:  q <= {q[WIDTH-2:0], sin_lsb};
            MODE_SHR:  q <= {sin_msb, q[WIDTH-1:1]};
            MODE_LOAD: q <= pin;
            default:   q <= q;
         endcase
      end
   end

   // clr has priority inside the counter, so a clear never counts as a shift.
   frame_counter #(
      .MOD (WIDTH)
   ) u_frame_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (shift_inc),
      .count (count),
      .wrap  (word_valid)
   );

   assign sout_msb = q[WIDTH-1];
   assign sout_lsb = q[0];

endmodule
